data_sram_responder: RTL and testbench

- Responder (slave) end of the pipeline's data SRAM interface; the execute stage is the initiator and drives en/we/addr/wdata.
- Holds a synchronous word-organised data memory with byte write enables and a configurable read-latency pipeline.
- Adds an out-of-range detector and a saturating write-activity counter.
- Serves as the data memory in CPU simulation and as the target model when verifying the initiating stage.

---
 rtl/data_sram_responder_if.sv | 21 ++
 rtl/data_sram_responder.sv | 78 +++++++
 tb/tb_data_sram_responder.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_sram_responder_if.sv
// Data SRAM request/response bundle between the execute stage (master) and the memory (slave).
interface data_sram_responder_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        rdata_valid;
    logic        addr_err;
    logic [15:0] wr_count;

    modport master (
        output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata, rdata_valid, addr_err, wr_count
    );

    modport slave (
        input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        output data_sram_rdata, rdata_valid, addr_err, wr_count
    );
endinterface

// File: rtl/data_sram_responder.sv
// Word-organised data SRAM with byte enables, range checking and a saturating write counter.
// Latency LATENCY cycles request->rdata_valid; no backpressure, one request accepted every cycle.
module data_sram_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 1,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input logic                  clk,
    input logic                  resetn,
    data_sram_responder_if.slave bus
);
    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned TAG_LSB = DEPTH_LOG2 + 2;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  in_range;
    logic                  wr_req;
    logic [31:0]           old_word;

    logic [LATENCY-1:0]    pipe_vld;
    logic [LATENCY-1:0]    pipe_err;
    logic [31:0]           pipe_dat [LATENCY];
    logic [15:0]           wr_count_q;

    assign word_idx = bus.data_sram_addr[TAG_LSB-1:2];
    assign in_range = (bus.data_sram_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
    assign wr_req   = bus.data_sram_en && in_range && (bus.data_sram_we != 4'h0);
    assign old_word = mem[word_idx];

    // Memory array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_req) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.data_sram_we[i]) begin
                    mem[word_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Data stages only load behind a valid entry, so the last stage holds like an SRAM output.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pipe_vld <= '0;
            pipe_err <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_dat[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= bus.data_sram_en;
            pipe_err[0] <= bus.data_sram_en && !in_range;
            if (bus.data_sram_en) begin
                pipe_dat[0] <= in_range ? old_word : 32'h0;
            end
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_err[i] <= pipe_err[i-1];
                if (pipe_vld[i-1]) begin
                    pipe_dat[i] <= pipe_dat[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_count_q <= 16'h0;
        end else if (wr_req && (wr_count_q != 16'hFFFF)) begin
            wr_count_q <= wr_count_q + 16'd1;
        end
    end

    assign bus.data_sram_rdata = pipe_dat[LATENCY-1];
    assign bus.rdata_valid     = pipe_vld[LATENCY-1];
    assign bus.addr_err        = pipe_err[LATENCY-1];
    assign bus.wr_count        = wr_count_q;
endmodule

// File: tb/tb_data_sram_responder.sv
// Bench: three responders (LATENCY 1, 3, 4) share one request stream; a queue model plus literal checks.
module tb_data_sram_responder;
    localparam int LATS [3] = '{1, 3, 4};

    logic        clk = 1'b0;
    logic        resetn;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [2:0]  rv;
    logic [2:0]  ae;
    logic [31:0] rd [3];
    logic [15:0] wc [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_sram_responder_if bus_if ();
        data_sram_responder #(
            .DEPTH_LOG2 (10),
            .LATENCY    (LATS[g]),
            .BASE_ADDR  (32'h0000_0000)
        ) dut (
            .clk    (clk),
            .resetn (resetn),
            .bus    (bus_if)
        );
        assign bus_if.data_sram_en    = en;
        assign bus_if.data_sram_we    = we;
        assign bus_if.data_sram_addr  = addr;
        assign bus_if.data_sram_wdata = wdata;
        assign rv[g] = bus_if.rdata_valid;
        assign ae[g] = bus_if.addr_err;
        assign rd[g] = bus_if.data_sram_rdata;
        assign wc[g] = bus_if.wr_count;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: one record per clock edge since reset; memory as an associative array of words.
    typedef struct {
        bit          v;
        bit          e;
        bit          k;
        logic [31:0] d;
    } rec_t;

    rec_t            hist [$];
    logic [31:0]     mref [int];
    int unsigned     wcnt;

    always @(posedge clk or negedge resetn) begin
        rec_t        r;
        logic [31:0] w;
        int          idx;
        if (!resetn) begin
            hist.delete();
            wcnt = 0;
        end else begin
            r.v = en; r.e = 1'b0; r.k = 1'b1; r.d = 32'h0;
            idx = int'(addr[11:2]);
            if (en) begin
                if (addr[31:12] != 20'h0) begin
                    r.e = 1'b1;
                end else begin
                    if (mref.exists(idx)) begin
                        w = mref[idx];
                        r.d = w;
                    end else begin
                        w = 32'h0;
                        r.k = 1'b0;
                    end
                    if (we != 4'h0) begin
                        for (int b = 0; b < 4; b++)
                            if (we[b]) w[8*b +: 8] = wdata[8*b +: 8];
                        if (r.k || we == 4'hF) mref[idx] = w;
                        wcnt++;
                    end
                end
            end
            hist.push_back(r);
        end
    end

    always @(negedge clk) begin
        int          j;
        bit          ev;
        bit          ee;
        bit          known;
        logic [31:0] ed;
        logic [15:0] ewc;
        for (int g = 0; g < 3; g++) begin
            if (!resetn) begin
                chk($sformatf("L%0d reset vld", LATS[g]), {31'h0, rv[g]}, 32'h0);
                chk($sformatf("L%0d reset err", LATS[g]), {31'h0, ae[g]}, 32'h0);
                chk($sformatf("L%0d reset rdata", LATS[g]), rd[g], 32'h0);
                chk($sformatf("L%0d reset wr_count", LATS[g]), {16'h0, wc[g]}, 32'h0);
            end else begin
                j = hist.size() - LATS[g];
                ev = 1'b0; ee = 1'b0; known = 1'b1; ed = 32'h0;
                if (j >= 0) begin
                    ev = hist[j].v;
                    ee = hist[j].v && hist[j].e;
                end
                for (int k = j; k >= 0; k--) begin
                    if (hist[k].v) begin
                        ed = hist[k].d;
                        known = hist[k].k;
                        break;
                    end
                end
                ewc = (wcnt > 32'd65535) ? 16'hFFFF : wcnt[15:0];
                chk($sformatf("L%0d vld", LATS[g]), {31'h0, rv[g]}, {31'h0, ev});
                chk($sformatf("L%0d err", LATS[g]), {31'h0, ae[g]}, {31'h0, ee});
                if (known) chk($sformatf("L%0d rdata", LATS[g]), rd[g], ed);
                chk($sformatf("L%0d wr_count", LATS[g]), {16'h0, wc[g]}, {16'h0, ewc});
            end
        end
    end

    task automatic cyc(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en = e; we = w; addr = a; wdata = d;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] exp_rd;
        logic        seen;
        en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("init vld", {31'h0, rv[g]}, 32'h0);
            chk("init rdata", rd[g], 32'h0);
            chk("init wr_count", {16'h0, wc[g]}, 32'h0);
        end
        @(posedge clk);
        #2 resetn = 1'b1;

        // Preload the words used below.
        cyc(1'b1, 4'hF, 32'h00, 32'h1);
        cyc(1'b1, 4'hF, 32'h04, 32'h2);
        cyc(1'b1, 4'hF, 32'h08, 32'h3);
        cyc(1'b1, 4'hF, 32'h0C, 32'h4);
        cyc(1'b1, 4'hF, 32'h10, 32'h0);
        cyc(1'b1, 4'hF, 32'h20, 32'h1122_3344);
        cyc(1'b1, 4'hF, 32'h40, 32'h0);
        idle(6);

        // Write then read-back, LATENCY=1.
        cyc(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        cyc(1'b1, 4'h0, 32'h10, 32'h0);
        chk("raw vld", {31'h0, rv[0]}, 32'h1);
        chk("raw rdata", rd[0], 32'hDEAD_BEEF);
        chk("raw wr_count", {16'h0, wc[0]}, 32'd8);

        // Byte-lane merge, read-first on the write itself.
        cyc(1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD);
        chk("lane readfirst", rd[0], 32'h1122_3344);
        cyc(1'b1, 4'h0, 32'h20, 32'h0);
        chk("lane merged", rd[0], 32'h11BB_33DD);
        idle(4);

        // LATENCY=3 burst of 8 reads, second half with addr[1:0]=2'b11.
        for (int k = 0; k < 12; k++) begin
            if (k < 8) cyc(1'b1, 4'h0, 32'((k % 4) * 4 + ((k >= 4) ? 3 : 0)), 32'h0);
            else       cyc(1'b0, 4'h0, 32'h0, 32'h0);
            if (k >= 2 && k < 10) begin
                exp_rd = 32'((k - 2) % 4 + 1);
                chk("burst vld", {31'h0, rv[1]}, 32'h1);
                chk("burst rdata", rd[1], exp_rd);
            end else begin
                chk("burst idle vld", {31'h0, rv[1]}, 32'h0);
            end
        end
        idle(2);

        // Out-of-range write.
        cyc(1'b1, 4'hF, 32'h0000_1000, 32'h55);
        chk("oor vld", {31'h0, rv[0]}, 32'h1);
        chk("oor err", {31'h0, ae[0]}, 32'h1);
        chk("oor rdata", rd[0], 32'h0);
        chk("oor wr_count", {16'h0, wc[0]}, 32'd9);
        cyc(1'b1, 4'h0, 32'h0, 32'h0);
        chk("oor word0", rd[0], 32'h1);
        chk("oor err clr", {31'h0, ae[0]}, 32'h0);
        idle(4);

        // Reset with two reads in flight at LATENCY=4.
        cyc(1'b1, 4'h0, 32'h4, 32'h0);
        cyc(1'b1, 4'h0, 32'h8, 32'h0);
        en = 1'b0; we = 4'h0; addr = 32'h0;
        resetn = 1'b0;
        #1;
        chk("midrst vld", {31'h0, rv[2]}, 32'h0);
        chk("midrst rdata", rd[2], 32'h0);
        chk("midrst wr_count", {16'h0, wc[2]}, 32'h0);
        @(posedge clk);
        #2 resetn = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idle(1);
            seen = seen | rv[2];
        end
        chk("midrst no late vld", {31'h0, seen}, 32'h0);
        cyc(1'b1, 4'h0, 32'h4, 32'h0);
        idle(3);
        chk("midrst reread vld", {31'h0, rv[2]}, 32'h1);
        chk("midrst reread", rd[2], 32'h2);

        // Write counter saturation.
        for (int i = 0; i < 65536; i++) cyc(1'b1, 4'hF, 32'h40, 32'(i));
        for (int g = 0; g < 3; g++) chk("sat wr_count", {16'h0, wc[g]}, 32'h0000_FFFF);
        cyc(1'b1, 4'hF, 32'h40, 32'h1234);
        for (int g = 0; g < 3; g++) chk("sat hold", {16'h0, wc[g]}, 32'h0000_FFFF);
        chk("sat readfirst", rd[0], 32'h0000_FFFF);
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
